// File: rtl/shared_mem_arbiter_pkg.sv
// Shared types and constants for the shared memory arbiter.
package mem_arb_pkg;

  // Owner of an outstanding read response.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_D    = 2'd2,
    OWN_IF   = 2'd3
  } owner_t;

  // Saturation value of the fetch starvation counter.
  localparam logic [3:0] STARVE_MAX = 4'd15;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_LD = 0;
  localparam int GNT_D  = 1;
  localparam int GNT_IF = 2;

  // Map a one-hot grant vector to the requester that owns it.
  function automatic owner_t gnt_owner(input logic [2:0] gnt);
    owner_t o;
    case (gnt)
      3'b001:  o = OWN_LD;
      3'b010:  o = OWN_D;
      3'b100:  o = OWN_IF;
      default: o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/shared_mem_arbiter_prio.sv
// Combinational grant selector: loader > data > fetch, with fetch promotion.
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  logic       ld_mode,
  input  logic       ld_req,
  input  logic       d_req,
  input  logic       if_req,
  input  logic       promote,
  output logic [2:0] gnt
);

  // Pick exactly one requester (or none); loader mode locks out the CPU.
  always_comb begin
    gnt = 3'b000;
    if (ld_mode) begin
      if (ld_req) begin
        gnt[GNT_LD] = 1'b1;
      end else begin
        gnt = 3'b000;
      end
    end else if (promote && if_req) begin
      gnt[GNT_IF] = 1'b1;
    end else if (d_req) begin
      gnt[GNT_D] = 1'b1;
    end else if (if_req) begin
      gnt[GNT_IF] = 1'b1;
    end else begin
      gnt = 3'b000;
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Single-port memory arbiter for CPU fetch, CPU data and program loader.
module shared_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_mode,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [2:0] sel;
  logic [2:0] gnt;
  logic       promote;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  owner_t     owner_q, owner_d;

  // Fetch overrides data once it has waited long enough (never in loader mode).
  assign promote = (starve_cnt_q >= LIMIT) && !ld_mode;

  mem_arb_prio u_prio (
    .ld_mode (ld_mode),
    .ld_req  (ld_req),
    .d_req   (d_req),
    .if_req  (if_req),
    .promote (promote),
    .gnt     (sel)
  );

  // Grants are combinational but held low during reset.
  always_comb begin
    if (rst) begin
      gnt = 3'b000;
    end else begin
      gnt = sel;
    end
  end

  assign ld_gnt    = gnt[GNT_LD];
  assign d_gnt     = gnt[GNT_D];
  assign if_gnt    = gnt[GNT_IF];
  assign cpu_stall = (if_req & ~if_gnt) | (d_req & ~d_gnt);

  // Memory command is the granted payload; fetch is always a read.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (gnt)
      3'b001: begin
        mem_en    = 1'b1;
        mem_we    = ld_we;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      3'b010: begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      3'b100: begin
        mem_en    = 1'b1;
        mem_addr  = if_addr;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // Count consecutive denied fetch cycles, saturating; clear on grant or idle.
  always_comb begin
    if (if_req && !if_gnt) begin
      if (starve_cnt_q == STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q;
      end else begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end else begin
      starve_cnt_d = 4'd0;
    end
  end

  // Only reads leave a response owner behind; writes return nothing.
  always_comb begin
    if (mem_en && !mem_we) begin
      owner_d = gnt_owner(gnt);
    end else begin
      owner_d = OWN_NONE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= 4'd0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Route memory read data to the recorded owner; a reset drops the response.
  always_comb begin
    ld_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rvalid = 1'b0;
    rdata     = '0;
    if (rst) begin
      rdata = '0;
    end else begin
      case (owner_q)
        OWN_LD:  ld_rvalid = 1'b1;
        OWN_D:   d_rvalid  = 1'b1;
        OWN_IF:  if_rvalid = 1'b1;
        default: rdata     = '0;
      endcase
      if (owner_q != OWN_NONE) begin
        rdata = mem_rdata;
      end else begin
        rdata = '0;
      end
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench: stimulus pushes expected read responses, a monitor pops and compares.
module tb_shared_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int LIM = 4;

  logic          clk;
  logic          rst;
  logic          ld_mode, ld_req, ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt, ld_rvalid;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          cpu_stall;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  logic [DW-1:0] mem [0:(1<<AW)-1];

  shared_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .ld_mode(ld_mode), .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory macro model
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // One cycle: check grants/stall at the negedge, then queue the expected response.
  task automatic step(input logic [2:0] exp_gnt, input logic exp_stall,
                      input logic push, input logic [1:0] own,
                      input logic [31:0] data, input string name);
    @(negedge clk);
    checks++;
    if ({if_gnt, d_gnt, ld_gnt} !== exp_gnt || mem_en !== (|exp_gnt)) begin
      errors++;
      $display("FAIL %s gnt: got {if,d,ld}=%b mem_en=%b, expected %b", name,
               {if_gnt, d_gnt, ld_gnt}, mem_en, exp_gnt);
    end
    checks++;
    if (cpu_stall !== exp_stall) begin
      errors++;
      $display("FAIL %s stall: got %b, expected %b", name, cpu_stall, exp_stall);
    end
    @(posedge clk);
    if (push) exp_q.push_back({own, data});
    #1;
  endtask

  // Check that no response and no command is presented this cycle.
  task automatic check_quiet(input string name);
    @(negedge clk);
    checks++;
    if ({ld_rvalid, d_rvalid, if_rvalid, mem_en} !== 4'b0000 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL %s quiet: got rvalid{ld,d,if}=%b mem_en=%b rdata=%h, expected all zero",
               name, {ld_rvalid, d_rvalid, if_rvalid}, mem_en, rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ld_mode = 1'b0; ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    if_req = 1'b0; if_addr = '0;
  endtask

  // Monitor: response routing, grant exclusivity and fetch wait bound.
  initial begin : monitor
    int nv;
    int wait_cnt;
    logic [33:0] e;
    logic [1:0] got_own;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      checks++;
      if (!$onehot0({if_gnt, d_gnt, ld_gnt})) begin
        errors++;
        $display("FAIL onehot: got {if,d,ld}=%b, expected at most one", {if_gnt, d_gnt, ld_gnt});
      end
      nv = int'(ld_rvalid) + int'(d_rvalid) + int'(if_rvalid);
      if (nv != 0) begin
        checks++;
        got_own = ld_rvalid ? 2'd1 : (d_rvalid ? 2'd2 : 2'd3);
        if (nv > 1) begin
          errors++;
          $display("FAIL rvalid_multi: got {ld,d,if}=%b, expected one", {ld_rvalid, d_rvalid, if_rvalid});
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexp: got owner %0d rdata=%h, expected no response", got_own, rdata);
        end else begin
          e = exp_q.pop_front();
          if (got_own !== e[33:32] || rdata !== e[31:0]) begin
            errors++;
            $display("FAIL resp: got owner %0d rdata=%h, expected owner %0d rdata=%h",
                     got_own, rdata, e[33:32], e[31:0]);
          end
        end
      end
      if (!rst && !ld_mode && if_req && !if_gnt) begin
        wait_cnt++;
        checks++;
        if (wait_cnt > LIM) begin
          errors++;
          $display("FAIL starve: fetch waited %0d cycles, expected at most %0d", wait_cnt, LIM);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin : stim
    idle_all();
    rst = 1'b1;
    d_req = 1'b1; if_req = 1'b1;
    @(posedge clk); #1;
    step(3'b000, 1'b1, 1'b0, 2'd0, 32'h0, "reset_gnt");
    idle_all();
    check_quiet("reset_state");
    rst = 1'b0;
    step(3'b000, 1'b0, 1'b0, 2'd0, 32'h0, "idle");

    // Preload memory through the loader port
    ld_mode = 1'b1; ld_req = 1'b1; ld_we = 1'b1;
    ld_addr = 11'd5; ld_wdata = 32'hDEAD_BEEF;
    step(3'b001, 1'b0, 1'b0, 2'd0, 32'h0, "pre5");
    ld_addr = 11'd6; ld_wdata = 32'h6666_0006;
    step(3'b001, 1'b0, 1'b0, 2'd0, 32'h0, "pre6");
    ld_addr = 11'd9; ld_wdata = 32'h9999_0009;
    step(3'b001, 1'b0, 1'b0, 2'd0, 32'h0, "pre9");
    ld_we = 1'b0; ld_addr = 11'd6;
    step(3'b001, 1'b0, 1'b1, 2'd1, 32'h6666_0006, "ld_read6");
    idle_all();

    // Fetch only
    if_req = 1'b1; if_addr = 11'd5;
    step(3'b100, 1'b0, 1'b1, 2'd3, 32'hDEAD_BEEF, "fetch5");
    if_req = 1'b0;
    step(3'b000, 1'b0, 1'b0, 2'd0, 32'h0, "fetch5_idle");

    // Starvation: four data grants then a promoted fetch
    d_req = 1'b1; d_addr = 11'd5; if_req = 1'b1; if_addr = 11'd6;
    for (int i = 0; i < 4; i++) step(3'b010, 1'b1, 1'b1, 2'd2, 32'hDEAD_BEEF, "starve_d");
    step(3'b100, 1'b1, 1'b1, 2'd3, 32'h6666_0006, "starve_if");
    if_req = 1'b0;
    step(3'b010, 1'b0, 1'b1, 2'd2, 32'hDEAD_BEEF, "starve_resume");
    idle_all();
    step(3'b000, 1'b0, 1'b0, 2'd0, 32'h0, "idle2");

    // Loader mode holds off CPU requests
    ld_mode = 1'b1; ld_req = 1'b1; ld_we = 1'b1;
    d_req = 1'b1; d_addr = 11'd5; if_req = 1'b1; if_addr = 11'd0;
    for (int i = 0; i < 4; i++) begin
      ld_addr = AW'(i); ld_wdata = 32'(i + 1);
      step(3'b001, 1'b1, 1'b0, 2'd0, 32'h0, "ld_write");
    end
    ld_req = 1'b0;
    step(3'b000, 1'b1, 1'b0, 2'd0, 32'h0, "ld_noreq");
    // Loader mode off: ld_req ignored, starved fetch wins first
    ld_mode = 1'b0; ld_req = 1'b1; d_addr = 11'd1;
    step(3'b100, 1'b1, 1'b1, 2'd3, 32'h1, "post_ld_if0");
    if_addr = 11'd1;
    step(3'b010, 1'b1, 1'b1, 2'd2, 32'h2, "post_ld_d1");
    d_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if_addr = AW'(i);
      step(3'b100, 1'b0, 1'b1, 2'd3, 32'(i + 1), "post_ld_if");
    end
    idle_all();

    // Data write then read of the same word
    d_req = 1'b1; d_we = 1'b1; d_addr = 11'd7; d_wdata = 32'h55;
    step(3'b010, 1'b0, 1'b0, 2'd0, 32'h0, "d_write7");
    d_we = 1'b0;
    step(3'b010, 1'b0, 1'b1, 2'd2, 32'h55, "d_read7");
    idle_all();
    step(3'b000, 1'b0, 1'b0, 2'd0, 32'h0, "idle3");

    // Reset in the cycle after a fetch grant drops the response
    if_req = 1'b1; if_addr = 11'd5;
    step(3'b100, 1'b0, 1'b0, 2'd0, 32'h0, "fetch_pre_rst");
    if_req = 1'b0; rst = 1'b1;
    check_quiet("rst_drop");
    rst = 1'b0; if_req = 1'b1;
    step(3'b100, 1'b0, 1'b1, 2'd3, 32'hDEAD_BEEF, "fetch_post_rst");
    if_req = 1'b0;
    step(3'b000, 1'b0, 1'b0, 2'd0, 32'h0, "idle4");

    // Promoted fetch and data write to the same word: fetch sees old data
    d_req = 1'b1; d_addr = 11'd5; if_req = 1'b1; if_addr = 11'd9;
    for (int i = 0; i < 4; i++) step(3'b010, 1'b1, 1'b1, 2'd2, 32'hDEAD_BEEF, "hz_d");
    d_we = 1'b1; d_addr = 11'd9; d_wdata = 32'hAAAA_0000;
    step(3'b100, 1'b1, 1'b1, 2'd3, 32'h9999_0009, "hz_if_old");
    if_req = 1'b0;
    step(3'b010, 1'b0, 1'b0, 2'd0, 32'h0, "hz_write");
    d_we = 1'b0;
    step(3'b010, 1'b0, 1'b1, 2'd2, 32'hAAAA_0000, "hz_read_new");

    // Entering loader mode with a data read outstanding
    d_addr = 11'd7;
    step(3'b010, 1'b0, 1'b1, 2'd2, 32'h55, "d_before_ld");
    d_req = 1'b0; ld_mode = 1'b1; ld_req = 1'b1; ld_we = 1'b1;
    ld_addr = 11'd20; ld_wdata = 32'h20;
    step(3'b001, 1'b0, 1'b0, 2'd0, 32'h0, "ld_entry");
    idle_all();
    for (int i = 0; i < 3; i++) step(3'b000, 1'b0, 1'b0, 2'd0, 32'h0, "drain");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending responses, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Arbitrates one single-port, synchronous-read 32-bit memory between three requesters: the CPU instruction-fetch port, the CPU data port (the load/store path driven by `dmem_r`/`dmem_w`), and an external program loader. The block issues at most one memory access per cycle and routes each read response back to its owner one cycle later. It raises a stall to the CPU whenever a CPU request is pending and not granted. It sits between the `cpu` top level and the memory macro.

## Interface
- `ADDR_W`, 11, word address width; matches `instr_addr` and `data_addr`.
- `DATA_W`, 32, data width.
- `STARVE_LIMIT`, 4, consecutive denied cycles after which fetch is promoted; legal range 1–15.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ld_mode`  in  1  loader owns memory; CPU requests are held off while this is high.
- `ld_req` in 1, `ld_we` in 1, `ld_addr` in ADDR_W, `ld_wdata` in DATA_W: loader request.
- `ld_gnt` out 1, `ld_rvalid` out 1: loader grant and read-data valid.
- `d_req` in 1, `d_we` in 1, `d_addr` in ADDR_W, `d_wdata` in DATA_W: CPU data request.
- `d_gnt` out 1, `d_rvalid` out 1: CPU data grant and read-data valid.
- `if_req` in 1, `if_addr` in ADDR_W: fetch request; fetch is read-only.
- `if_gnt` out 1, `if_rvalid` out 1: fetch grant and read-data valid.
- `rdata`  out  DATA_W  read data shared by all requesters; qualified by the owner's `*_rvalid`.
- `mem_en`, `mem_we` out 1; `mem_addr` out ADDR_W; `mem_wdata` out DATA_W: memory command.
- `mem_rdata`  in  DATA_W  memory read data; valid one cycle after a read command.
- `cpu_stall`  out  1  high when (`if_req` & !`if_gnt`) | (`d_req` & !`d_gnt`).

## Operation
- Requester protocol:
  - A requester holds `req` and its payload stable until it samples `gnt` high.
  - `gnt` is combinational in the cycle of issue.
  - The accepted request is the one sampled on the same edge as `gnt`.
- Only one `*_gnt` is high per cycle. The memory command equals the granted payload, with `mem_en`=1.
- Priority order: loader > data > fetch.
  - While `ld_mode`=1, only the loader can be granted.
  - While `ld_mode`=0, `ld_req` is ignored.
- Starvation guard:
  - `starve_cnt` increments each cycle that `if_req`=1 and `if_gnt`=0, and saturates at 15.
  - It clears when fetch is granted or when `if_req`=0.
  - When `starve_cnt` ≥ `STARVE_LIMIT` and `ld_mode`=0, fetch beats data for exactly that grant.
- Read response tracking:
  - On each granted read, a registered `owner` field (NONE/LD/D/IF) records the requester.
  - Next cycle: `rdata`=`mem_rdata`, and the matching `*_rvalid`=1 for exactly one cycle.
  - Writes produce no rvalid.
- Back-to-back grants are allowed every cycle. A response and a new grant may coexist in the same cycle.
- Entry into `ld_mode` while a CPU read response is outstanding: the response is still delivered next cycle.

## Timing
- Grant-to-data latency is 1 cycle. Throughput is 1 access per cycle.
- Reset values: `owner`=NONE, `starve_cnt`=0, all `*_rvalid`=0, `rdata`=0.
  - Grants and `mem_en` are combinational. They are forced to 0 while `rst`=1.
- Reset asserted in the cycle after a read grant: the response is dropped, with no `*_rvalid`.
- Address wrap-around is the requester's responsibility. Addresses are passed through unmodified.
- Simultaneous data write and fetch at the same address with fetch promoted: fetch is issued first, then the write next cycle. The fetch returns the old data.

## Structure
- Shared package `mem_arb_pkg`:
  - The `owner_t` encoding: NONE=2'd0, LD=2'd1, D=2'd2, IF=2'd3.
  - `STARVE_MAX`=15.
- One sub-module, `mem_arb_prio`: the combinational grant selector. Its inputs are the requests, `ld_mode` and the promote flag; its output is a one-hot grant.
- The top level holds `starve_cnt`, the `owner` register and the response routing.

## Test plan
- Fetch only, `if_addr`=5, memory word 5 = 32'hDEAD_BEEF → `if_gnt` in the same cycle. Next cycle: `if_rvalid`=1 and `rdata`=32'hDEAD_BEEF. `cpu_stall`=0 throughout.
- Continuous `d_req` reads plus a continuous `if_req`, `STARVE_LIMIT`=4 → data is granted 4 cycles, then fetch on cycle 5, then data resumes. `cpu_stall`=1 in every cycle in which fetch waits.
- `ld_mode`=1 with loader writes of 32'h1..32'h4 to addresses 0..3, and `d_req`/`if_req` held high → only `ld_gnt` toggles and `cpu_stall`=1. After `ld_mode` falls, fetches of 0..3 return 1..4.
- Data write of 32'h55 to address 7, then a data read of address 7 on the next cycle → the read returns 32'h55. `d_rvalid` is asserted only for the read.
- Assert `rst` in the cycle after a fetch grant → no `if_rvalid`, and `rdata`=0. The next post-reset fetch completes normally.
- Random traffic on all three ports, checked against a reference memory model → every `*_rvalid` matches its owner. At most one grant per cycle. No fetch waits longer than `STARVE_LIMIT`+1 cycles while `ld_mode`=0.
